// File: rtl/usb_tx_pkg.sv
// Types and defaults shared by the CRC16 transmit arbiter and its round-robin picker.
package usb_tx_pkg;

    localparam int PKT_W_DEFAULT = 72;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_DONE,
        COOLDOWN
    } arb_state_t;

    typedef enum logic {
        OK,
        ERR
    } outcome_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request searching upward from last_ptr+1, wrapping.
module rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_ptr,
    output logic               any_req,
    output logic [IDX_W-1:0]   winner
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        any_req = 1'b0;
        winner  = '0;
        idx     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IDX_W'((int'(last_ptr) + k) % NUM_REQ);
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                winner  = idx;
            end
        end
    end

endmodule

// File: rtl/crc16_tx_arbiter.sv
// Shares one CRC16 encoder between NUM_REQ packet requesters: arbitrates, loads the packet,
// tracks the transfer to completion or timeout, then holds off for an inter-packet gap.
//
// state     | meaning
// IDLE      | arbitrating; winner's packet captured on the edge
// LOAD      | one-cycle start pulse to the encoder, gnt to the owner
// WAIT_DONE | encoder busy; timeout counter running
// COOLDOWN  | GAP-cycle gap; done/err reported in the first cycle
module crc16_tx_arbiter
    import usb_tx_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int PKT_W   = PKT_W_DEFAULT,
    parameter int TIMEOUT = 200,
    parameter int GAP     = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*PKT_W-1:0] pkt_in,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       done,
    output logic [NUM_REQ-1:0]       err,
    output logic                     enc_pkt_ready,
    output logic [PKT_W-1:0]         enc_pkt,
    input  logic                     enc_done,
    output logic                     enc_abort,
    output logic                     busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam int GAP_W = $clog2(GAP + 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);

    arb_state_t       state, state_nxt;
    logic [IDX_W-1:0] last_ptr, owner, winner;
    logic             any_req;
    logic [PKT_W-1:0] pkt_hold;
    logic [CNT_W-1:0] to_cnt;
    logic [GAP_W-1:0] gap_cnt;
    outcome_t         outcome;
    logic [PKT_W-1:0] pkt_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
        assign pkt_arr[i] = pkt_in[i*PKT_W +: PKT_W];
    end

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req      (req),
        .last_ptr (last_ptr),
        .any_req  (any_req),
        .winner   (winner)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            last_ptr <= IDX_W'(NUM_REQ - 1);
            owner    <= '0;
            pkt_hold <= '0;
            to_cnt   <= '0;
            gap_cnt  <= '0;
            outcome  <= OK;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        pkt_hold <= pkt_arr[winner];
                        owner    <= winner;
                        last_ptr <= winner;
                    end
                end
                LOAD: begin
                    to_cnt <= '0;
                end
                WAIT_DONE: begin
                    to_cnt  <= to_cnt + 1'b1;
                    gap_cnt <= '0;
                    if (enc_done) begin
                        outcome <= OK;
                    end else if (to_cnt == TO_LAST) begin
                        outcome <= ERR;
                    end
                end
                COOLDOWN: begin
                    gap_cnt <= gap_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt     = state;
        gnt           = '0;
        done          = '0;
        err           = '0;
        enc_pkt_ready = 1'b0;
        enc_pkt       = '0;
        enc_abort     = 1'b0;
        busy          = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (any_req) state_nxt = LOAD;
            end
            LOAD: begin
                state_nxt     = WAIT_DONE;
                enc_pkt_ready = 1'b1;
                gnt[owner]    = 1'b1;
                enc_pkt       = pkt_hold;
            end
            WAIT_DONE: begin
                enc_pkt = pkt_hold;
                // A completion landing on the last allowed cycle beats the timeout, so
                // the abort has to be qualified by enc_done in the same cycle.
                if (enc_done) begin
                    state_nxt = COOLDOWN;
                end else if (to_cnt == TO_LAST) begin
                    state_nxt = COOLDOWN;
                    enc_abort = 1'b1;
                end
            end
            COOLDOWN: begin
                if (gap_cnt == '0) begin
                    if (outcome == OK) done[owner] = 1'b1;
                    else               err[owner]  = 1'b1;
                end
                if (gap_cnt == GAP_LAST) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_crc16_tx_arbiter.sv
// Scoreboard bench for crc16_tx_arbiter: a transaction-level model predicts grant, abort and
// completion events with their cycle numbers; a negedge monitor pops and compares them.
module tb_crc16_tx_arbiter;

    localparam int NUM_REQ = 2;
    localparam int PKT_W   = 72;
    localparam int TIMEOUT = 200;
    localparam int GAP     = 2;

    localparam int EV_GNT   = 0;
    localparam int EV_ABORT = 1;
    localparam int EV_DONE  = 2;
    localparam int EV_ERR   = 3;

    typedef logic [PKT_W-1:0] pkt_t;
    typedef struct {
        int   kind;
        int   idx;
        int   cyc;
        pkt_t pkt;
    } ev_t;

    logic                     clock;
    logic                     reset;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*PKT_W-1:0] pkt_in;
    logic [NUM_REQ-1:0]       gnt;
    logic [NUM_REQ-1:0]       done;
    logic [NUM_REQ-1:0]       err;
    logic                     enc_pkt_ready;
    logic [PKT_W-1:0]         enc_pkt;
    logic                     enc_done;
    logic                     enc_abort;
    logic                     busy;

    crc16_tx_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PKT_W   (PKT_W),
        .TIMEOUT (TIMEOUT),
        .GAP     (GAP)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .req           (req),
        .pkt_in        (pkt_in),
        .gnt           (gnt),
        .done          (done),
        .err           (err),
        .enc_pkt_ready (enc_pkt_ready),
        .enc_pkt       (enc_pkt),
        .enc_done      (enc_done),
        .enc_abort     (enc_abort),
        .busy          (busy)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // model state: transfer window [m_lo, m_wend) drives enc_pkt, IDLE again from m_free
    pkt_t pend [NUM_REQ][$];
    ev_t  exp_q[$];
    int   m_lo = -10, m_wend = -10, m_free = -10, m_last = NUM_REQ - 1;
    pkt_t m_pkt = '0;
    int   enc_done_at = -1, spur_at = -1, pop_at = -1, pop_idx = 0, rel_at = -1;
    int   force_lat = 0, n_grants = 0;
    bit   spur_en = 0, drop_en = 0, mon_en = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc = cyc + 1;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic pkt_t rnd_pkt();
        logic [95:0] w;
        w = {$urandom(), $urandom(), $urandom()};
        return w[PKT_W-1:0];
    endfunction

    function automatic int pick_lat();
        int r;
        r = int'($urandom_range(0, 11));
        if (r == 0) return TIMEOUT + 1;
        if (r == 1) return TIMEOUT;
        return int'($urandom_range(1, 40));
    endfunction

    function automatic bit pend_empty();
        for (int i = 0; i < NUM_REQ; i++) if (pend[i].size() > 0) return 1'b0;
        return 1'b1;
    endfunction

    // Transaction-level prediction of one transfer started by arbitration in the current cycle.
    task automatic model_grant(input logic [NUM_REQ-1:0] r);
        int  w, n, l, c;
        ev_t e;
        w = -1;
        for (int k = 1; k <= NUM_REQ; k++)
            if (w < 0 && r[(m_last + k) % NUM_REQ]) w = (m_last + k) % NUM_REQ;
        n = (force_lat != 0) ? force_lat : pick_lat();
        l = cyc + 1;
        e.kind = EV_GNT; e.idx = w; e.cyc = l; e.pkt = pend[w][0];
        exp_q.push_back(e);
        if (n <= TIMEOUT) begin
            c = l + n + 1;
            enc_done_at = l + n;
            e.kind = EV_DONE;
        end else begin
            c = l + TIMEOUT + 1;
            enc_done_at = -1;
            e.kind = EV_ABORT; e.idx = 0; e.cyc = l + TIMEOUT; e.pkt = '0;
            exp_q.push_back(e);
            e.kind = EV_ERR;
        end
        e.idx = w; e.cyc = c; e.pkt = '0;
        exp_q.push_back(e);
        m_lo = l; m_wend = c; m_free = c + GAP; m_pkt = pend[w][0]; m_last = w;
        pop_at = l + 1; pop_idx = w;
        n_grants++;
    endtask

    task automatic tick();
        logic [NUM_REQ-1:0] r;
        @(posedge clock);
        #1;
        if (cyc == rel_at) reset = 1'b0;
        if (cyc == pop_at) void'(pend[pop_idx].pop_front());
        enc_done = (cyc == enc_done_at) || (cyc == spur_at);
        if (spur_en && !(cyc > m_lo && cyc < m_wend) && $urandom_range(0, 7) == 0) enc_done = 1'b1;
        r = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pend[i].size() > 0 && !(drop_en && $urandom_range(0, 7) == 0)) r[i] = 1'b1;
            pkt_in[i*PKT_W +: PKT_W] = (pend[i].size() > 0) ? pend[i][0] : '0;
        end
        req = r;
        if (!reset && cyc >= m_free && r != '0) model_grant(r);
    endtask

    task automatic run_idle(input int max);
        int k;
        k = 0;
        while (k < max && !(pend_empty() && cyc >= m_free && exp_q.size() == 0)) begin
            tick();
            k++;
        end
        checks++;
        if (k >= max) begin
            failures++;
            $display("FAIL drain: still %0d events pending after %0d cycles", exp_q.size(), max);
        end
    endtask

    task automatic wait_grant(input int max);
        int g0, k;
        g0 = n_grants; k = 0;
        while (k < max && n_grants == g0) begin
            tick();
            k++;
        end
        checks++;
        if (n_grants == g0) begin
            failures++;
            $display("FAIL wait_grant: no arbitration within %0d cycles", max);
        end
    endtask

    task automatic match(input int kind, input logic [NUM_REQ-1:0] vec);
        ev_t                e;
        logic [NUM_REQ-1:0] ev;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event: kind=%0d vec=%b at cycle %0d, nothing expected", kind, vec, cyc);
            return;
        end
        e = exp_q.pop_front();
        ev = '0;
        if (e.kind == EV_ABORT) ev[0] = 1'b1;
        else ev[e.idx] = 1'b1;
        chk("event_kind", 72'(kind), 72'(e.kind));
        chk("event_cycle", 72'(cyc), 72'(e.cyc));
        chk("event_vector", 72'(vec), 72'(ev));
        if (kind == EV_GNT) chk("gnt_enc_pkt", enc_pkt, e.pkt);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_gnt"}, 72'(gnt), 72'(0));
        chk({tag, "_done"}, 72'(done), 72'(0));
        chk({tag, "_err"}, 72'(err), 72'(0));
        chk({tag, "_enc_pkt_ready"}, 72'(enc_pkt_ready), 72'(0));
        chk({tag, "_enc_pkt"}, enc_pkt, 72'(0));
        chk({tag, "_enc_abort"}, 72'(enc_abort), 72'(0));
        chk({tag, "_busy"}, 72'(busy), 72'(0));
    endtask

    always @(negedge clock) begin
        if (!reset && mon_en) begin
            chk("busy", 72'(busy), 72'(cyc >= m_lo && cyc < m_free));
            chk("enc_pkt", enc_pkt, (cyc >= m_lo && cyc < m_wend) ? m_pkt : '0);
            chk("enc_pkt_ready", 72'(enc_pkt_ready), 72'(cyc == m_lo));
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                checks++;
                failures++;
                $display("FAIL missing_event: kind=%0d idx=%0d due cycle %0d, not seen by %0d",
                         exp_q[0].kind, exp_q[0].idx, exp_q[0].cyc, cyc);
                void'(exp_q.pop_front());
            end
            if (gnt != '0) match(EV_GNT, gnt);
            if (enc_abort) match(EV_ABORT, NUM_REQ'(1));
            if (done != '0) match(EV_DONE, done);
            if (err != '0) match(EV_ERR, err);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req = '0; pkt_in = '0; enc_done = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_all_zero("reset");
        @(posedge clock);
        #1;
        reset = 1'b0;
        mon_en = 1'b1;

        // single request, encoder finishes 90 cycles after the start pulse
        force_lat = 90;
        pend[0].push_back(72'hA5_0123456789ABCDEF);
        run_idle(400);

        // contention: both requesters hold two packets each
        for (int i = 0; i < NUM_REQ; i++) begin
            pend[i].push_back(rnd_pkt());
            pend[i].push_back(rnd_pkt());
        end
        run_idle(1000);

        // timeout, with a second request arriving during WAIT_DONE
        force_lat = TIMEOUT + 1;
        pend[1].push_back(rnd_pkt());
        wait_grant(20);
        force_lat = 30;
        repeat (10) tick();
        pend[0].push_back(rnd_pkt());
        run_idle(600);

        // enc_done on the very cycle the counter reaches TIMEOUT-1
        force_lat = TIMEOUT;
        pend[0].push_back(rnd_pkt());
        run_idle(600);

        // request withdrawn before it could be granted
        force_lat = 30;
        pend[0].push_back(rnd_pkt());
        wait_grant(20);
        pend[1].push_back(rnd_pkt());
        repeat (5) tick();
        pend[1].delete();
        run_idle(200);

        // request raised in the done cycle; spurious enc_done in COOLDOWN and IDLE
        force_lat = 20;
        pend[1].push_back(rnd_pkt());
        wait_grant(20);
        while (cyc < m_wend) tick();
        pend[0].push_back(rnd_pkt());
        spur_at = cyc + 1;
        run_idle(200);
        spur_at = cyc + 2;
        repeat (5) tick();

        // reset while the counter sits at 50 in WAIT_DONE
        force_lat = TIMEOUT + 1;
        pend[0].push_back(rnd_pkt());
        wait_grant(20);
        while (cyc < m_lo + 51) tick();
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        exp_q.delete();
        enc_done_at = -1; pop_at = -1; spur_at = -1;
        m_lo = -10; m_wend = -10; m_free = -10; m_last = NUM_REQ - 1;
        rel_at = cyc + 2;
        force_lat = 10;
        pend[1].push_back(rnd_pkt());
        pend[0].push_back(rnd_pkt());
        run_idle(300);

        // randomized traffic with dropped requests and spurious encoder pulses
        force_lat = 0;
        spur_en = 1'b1;
        drop_en = 1'b1;
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < NUM_REQ; i++)
                if (pend[i].size() < 3 && $urandom_range(0, 2) == 0) pend[i].push_back(rnd_pkt());
            repeat ($urandom_range(1, 30)) tick();
        end
        run_idle(3000);
        spur_en = 1'b0;
        drop_en = 1'b0;
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
